fsmd_calc_param: RTL



---
 rtl/fsmd_calc_param.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fsmd_calc_param.sv
// -----------------------------------------------------------------------------
// fsmd_calc_param
//   Keypad-driven calculator FSMD. Collects operand A, an opcode and operand B
//   from single-cycle key strobes and executes add, sub or an iterative
//   shift-add multiply. Reports carry/borrow/truncation on ovf, shows busy
//   while executing and, with CHAIN=1, lets the next opcode continue from the
//   previous result.
//
// Parameters
//   DATA_W : key/operand width (>= 2)
//   RES_W  : accumulator/result width (>= DATA_W+1)
//   CHAIN  : 1 = key in DONE is an opcode on the previous result,
//            0 = key in DONE starts a new calculation as operand A
//
// Ports
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   valid_key : one-cycle key strobe
//   key       : operand value, or opcode in key[1:0]
//   result    : registered result, valid while done=1
//   done      : high while a completed result is held
//   busy      : high while executing; keys are ignored
//   ovf       : carry/borrow/truncation flag for the current result
// -----------------------------------------------------------------------------
module fsmd_calc_param #(
  parameter int DATA_W = 4,
  parameter int RES_W  = 2 * DATA_W,
  parameter int CHAIN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_key,
  input  logic [DATA_W-1:0] key,
  output logic [RES_W-1:0]  result,
  output logic              done,
  output logic              busy,
  output logic              ovf
);

  localparam int PROD_W = RES_W + DATA_W;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_CLR = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_OP,
    S_WAIT_B,
    S_EXEC,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [RES_W-1:0]    acc_q, acc_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [1:0]          op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                ovf_q, ovf_d;

  logic [RES_W:0]      sum_w;
  logic [RES_W:0]      diff_w;
  logic [PROD_W-1:0]   prod_nx;

  function automatic logic [RES_W-1:0] zext_key(input logic [DATA_W-1:0] k);
    zext_key = {{(RES_W - DATA_W){1'b0}}, k};
  endfunction

  // {carry, sum}
  function automatic logic [RES_W:0] add_carry(input logic [RES_W-1:0] a,
                                               input logic [RES_W-1:0] b);
    add_carry = {1'b0, a} + {1'b0, b};
  endfunction

  // {borrow, difference}: the extra top bit is set exactly when a < b
  function automatic logic [RES_W:0] sub_borrow(input logic [RES_W-1:0] a,
                                                input logic [RES_W-1:0] b);
    sub_borrow = {1'b0, a} - {1'b0, b};
  endfunction

  // Anything above RES_W in the full product is lost to truncation
  function automatic logic mul_trunc(input logic [PROD_W-1:0] p);
    mul_trunc = |p[PROD_W-1:RES_W];
  endfunction

  assign sum_w   = add_carry(acc_q, zext_key(b_q));
  assign diff_w  = sub_borrow(acc_q, zext_key(b_q));
  // b_q is shifted right each multiply step, so bit 0 is always the current B bit
  assign prod_nx = prod_q + (b_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    done_d   = done_q;
    busy_d   = busy_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (valid_key) begin
          acc_d   = zext_key(key);
          state_d = S_WAIT_OP;
        end
      end

      S_WAIT_OP: begin
        if (valid_key) begin
          if (key[1:0] == OP_CLR) begin
            result_d = '0;
            ovf_d    = 1'b0;
            state_d  = S_IDLE;
          end else begin
            op_d    = key[1:0];
            state_d = S_WAIT_B;
          end
        end
      end

      S_WAIT_B: begin
        if (valid_key) begin
          b_d     = key;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          prod_d  = '0;
          mcand_d = {{DATA_W{1'b0}}, acc_q};
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        unique case (op_q)
          OP_ADD: begin
            result_d = sum_w[RES_W-1:0];
            ovf_d    = sum_w[RES_W];
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
          OP_SUB: begin
            result_d = diff_w[RES_W-1:0];
            ovf_d    = diff_w[RES_W];
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = S_DONE;
          end
          OP_MUL: begin
            prod_d  = prod_nx;
            mcand_d = mcand_q << 1;
            b_d     = b_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
              result_d = prod_nx[RES_W-1:0];
              ovf_d    = mul_trunc(prod_nx);
              busy_d   = 1'b0;
              done_d   = 1'b1;
              state_d  = S_DONE;
            end
          end
          default: begin
            // clear is filtered before EXEC; recover to a clean idle state
            result_d = '0;
            ovf_d    = 1'b0;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end
        endcase
      end

      S_DONE: begin
        if (valid_key) begin
          done_d = 1'b0;
          if (CHAIN != 0) begin
            if (key[1:0] == OP_CLR) begin
              result_d = '0;
              ovf_d    = 1'b0;
              state_d  = S_IDLE;
            end else begin
              acc_d   = result_q;
              op_d    = key[1:0];
              state_d = S_WAIT_B;
            end
          end else begin
            acc_d   = zext_key(key);
            state_d = S_WAIT_OP;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign ovf    = ovf_q;

endmodule
